// File: rtl/change_dispenser_ctrl.sv
// Greedy coin payout sequencer driving a 4-phase req/ack hopper, with ack timeout fault.
// Optional per-denomination coin counters when CHANGE_COIN_COUNT_EN is defined.
module change_dispenser_ctrl #(
  parameter int unsigned COIN_HI     = 5,
  parameter int unsigned COIN_MID    = 2,
  parameter int unsigned COIN_LO     = 1,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] moneyToGive,
  input  logic       coinAck,
  input  logic       clearFault,
  output logic       coinReq,
  output logic [1:0] coinSel,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [4:0] paidTotal
`ifdef CHANGE_COIN_COUNT_EN
  ,
  output logic [2:0] cntHi,
  output logic [2:0] cntMid,
  output logic [2:0] cntLo
`endif
);

  typedef enum logic [2:0] {IDLE, REQ, REL, DONE, WCLR, FAULT} state_t;

  localparam logic [4:0] HI_V     = 5'(COIN_HI);
  localparam logic [4:0] MID_V    = 5'(COIN_MID);
  localparam logic [4:0] LO_V     = 5'(COIN_LO);
  localparam logic [3:0] TMO_LAST = 4'(ACK_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [4:0]  remaining_q, remaining_d;
  logic [4:0]  paid_q, paid_d;
  logic [3:0]  timer_q, timer_d;
  logic        armed_q, armed_d;
  logic        req_q, req_d;
  logic [1:0]  sel_q, sel_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic [2:0]  cnt_hi_q, cnt_hi_d;
  logic [2:0]  cnt_mid_q, cnt_mid_d;
  logic [2:0]  cnt_lo_q, cnt_lo_d;

  function automatic logic [1:0] pick(input logic [4:0] amt);
    if (amt >= HI_V)       return 2'd2;
    else if (amt >= MID_V) return 2'd1;
    else                   return 2'd0;
  endfunction

  function automatic logic [4:0] coin_val(input logic [1:0] sel);
    case (sel)
      2'd2:    return HI_V;
      2'd1:    return MID_V;
      default: return LO_V;
    endcase
  endfunction

  function automatic logic [2:0] sat_inc(input logic [2:0] c);
    return (c == 3'd7) ? c : c + 3'd1;
  endfunction

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    paid_d      = paid_q;
    timer_d     = timer_q;
    armed_d     = armed_q;
    sel_d       = sel_q;
    cnt_hi_d    = cnt_hi_q;
    cnt_mid_d   = cnt_mid_q;
    cnt_lo_d    = cnt_lo_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (moneyToGive == 5'd0) begin
          armed_d = 1'b1;
        end else if (armed_q && moneyToGive == 5'd31) begin
          paid_d  = '0;
          state_d = DONE;
        end else if (armed_q) begin
          remaining_d = moneyToGive;
          paid_d      = '0;
          sel_d       = pick(moneyToGive);
          cnt_hi_d    = '0;
          cnt_mid_d   = '0;
          cnt_lo_d    = '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        // Ack is checked before the timeout so a same-cycle ack is accepted.
        if (coinAck) begin
          remaining_d = remaining_q - coin_val(sel_q);
          paid_d      = paid_q + coin_val(sel_q);
          timer_d     = '0;
          state_d     = REL;
          case (sel_q)
            2'd2:    cnt_hi_d  = sat_inc(cnt_hi_q);
            2'd1:    cnt_mid_d = sat_inc(cnt_mid_q);
            default: cnt_lo_d  = sat_inc(cnt_lo_q);
          endcase
        end else if (timer_q == TMO_LAST) begin
          timer_d = '0;
          state_d = FAULT;
        end else begin
          timer_d = timer_q + 4'd1;
        end
      end
      REL: begin
        if (!coinAck) begin
          if (remaining_q == 5'd0) begin
            state_d = DONE;
          end else begin
            sel_d   = pick(remaining_q);
            state_d = REQ;
          end
        end
      end
      DONE: begin
        armed_d = 1'b0;
        state_d = WCLR;
      end
      WCLR: begin
        if (moneyToGive == 5'd0) begin
          armed_d = 1'b1;
          state_d = IDLE;
        end
      end
      FAULT: begin
        if (clearFault) begin
          armed_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    req_d   = (state_d == REQ);
    busy_d  = (state_d != IDLE) && (state_d != FAULT);
    done_d  = (state_d == DONE);
    fault_d = (state_d == FAULT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      paid_q      <= '0;
      timer_q     <= '0;
      armed_q     <= 1'b1;
      req_q       <= 1'b0;
      sel_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      cnt_hi_q    <= '0;
      cnt_mid_q   <= '0;
      cnt_lo_q    <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      paid_q      <= paid_d;
      timer_q     <= timer_d;
      armed_q     <= armed_d;
      req_q       <= req_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      cnt_hi_q    <= cnt_hi_d;
      cnt_mid_q   <= cnt_mid_d;
      cnt_lo_q    <= cnt_lo_d;
    end
  end

  assign coinReq   = req_q;
  assign coinSel   = sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign paidTotal = paid_q;

`ifdef CHANGE_COIN_COUNT_EN
  assign cntHi  = cnt_hi_q;
  assign cntMid = cnt_mid_q;
  assign cntLo  = cnt_lo_q;
`else
  logic unused_cnt;
  assign unused_cnt = ^{cnt_hi_q, cnt_mid_q, cnt_lo_q};
`endif

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// Scoreboard bench for change_dispenser_ctrl: greedy payout model, hopper responder, monitor.
module tb_change_dispenser_ctrl;

  logic       clock;
  logic       reset;
  logic [4:0] moneyToGive;
  logic       coinAck;
  logic       clearFault;
  logic       coinReq;
  logic [1:0] coinSel;
  logic       busy;
  logic       done;
  logic       fault;
  logic [4:0] paidTotal;
`ifdef CHANGE_COIN_COUNT_EN
  logic [2:0] cntHi, cntMid, cntLo;
`endif

  change_dispenser_ctrl #(.COIN_HI(5), .COIN_MID(2), .COIN_LO(1), .ACK_TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .moneyToGive(moneyToGive), .coinAck(coinAck),
    .clearFault(clearFault), .coinReq(coinReq), .coinSel(coinSel), .busy(busy),
    .done(done), .fault(fault), .paidTotal(paidTotal)
`ifdef CHANGE_COIN_COUNT_EN
    , .cntHi(cntHi), .cntMid(cntMid), .cntLo(cntLo)
`endif
  );

  // kind: 0 = coin request, 1 = done pulse, 2 = fault, -1 = nothing expected
  typedef struct {
    int kind;
    int sel;
    int total;
    int hi;
    int mid;
    int lo;
  } item_t;

  item_t q[$];
  int    n_total = 0;
  int    n_pass  = 0;
  int    ack_dly = 2;
  int    rel_dly = 0;
  bit    never_ack = 0;

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic item_t pop_exp();
    item_t it;
    if (q.size() == 0) begin
      it.kind = -1; it.sel = -1; it.total = -1; it.hi = -1; it.mid = -1; it.lo = -1;
    end else begin
      it = q.pop_front();
    end
    return it;
  endfunction

  // Reference model: greedy 5/2/1 breakdown computed arithmetically.
  task automatic push_payout(input int amt, input bit stall_first);
    item_t it;
    int rem, tot, c;
    if (amt == 31) begin
      it = '{kind: 1, sel: 0, total: 0, hi: 0, mid: 0, lo: 0};
      q.push_back(it);
      return;
    end
    rem = amt;
    tot = 0;
    while (rem > 0) begin
      c = (rem >= 5) ? 5 : (rem >= 2) ? 2 : 1;
      it = '{kind: 0, sel: (c == 5) ? 2 : (c == 2) ? 1 : 0, total: tot, hi: 0, mid: 0, lo: 0};
      q.push_back(it);
      if (stall_first) begin
        it = '{kind: 2, sel: 0, total: 0, hi: 0, mid: 0, lo: 0};
        q.push_back(it);
        return;
      end
      tot += c;
      rem -= c;
    end
    it = '{kind: 1, sel: 0, total: amt, hi: amt / 5, mid: (amt % 5) / 2, lo: (amt % 5) % 2};
    q.push_back(it);
  endtask

  // Hopper: raises ack ack_dly cycles into a request, drops it rel_dly cycles after req falls.
  initial begin
    int wcnt, rcnt;
    coinAck = 0;
    wcnt = 0;
    rcnt = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        coinAck = 0; wcnt = 0; rcnt = 0;
      end else if (coinReq && !coinAck) begin
        if (!never_ack) begin
          wcnt++;
          if (wcnt >= ack_dly) begin coinAck = 1; wcnt = 0; end
        end
      end else if (!coinReq) begin
        wcnt = 0;
        if (coinAck) begin
          if (rcnt >= rel_dly) begin coinAck = 0; rcnt = 0; end
          else rcnt++;
        end
      end
    end
  end

  // Monitor
  initial begin
    bit prev_req, prev_fault;
    int held_sel;
    item_t it;
    prev_req = 0;
    prev_fault = 0;
    held_sel = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev_req = 0;
        prev_fault = 0;
      end else begin
        if (coinReq && !prev_req) begin
          it = pop_exp();
          chk("coin_event_kind", 0, it.kind);
          chk("coin_sel", int'(coinSel), it.sel);
          chk("paid_before_coin", int'(paidTotal), it.total);
          held_sel = int'(coinSel);
        end else if (coinReq) begin
          chk("coin_sel_stable", int'(coinSel), held_sel);
        end
        if (done) begin
          it = pop_exp();
          chk("done_event_kind", 1, it.kind);
          chk("done_paid_total", int'(paidTotal), it.total);
`ifdef CHANGE_COIN_COUNT_EN
          if (it.total != 0) begin
            chk("cnt_hi", int'(cntHi), it.hi);
            chk("cnt_mid", int'(cntMid), it.mid);
            chk("cnt_lo", int'(cntLo), it.lo);
          end
`endif
        end
        if (fault && !prev_fault) begin
          it = pop_exp();
          chk("fault_event_kind", 2, it.kind);
          chk("fault_req_low", int'(coinReq), 0);
          chk("fault_busy_low", int'(busy), 0);
        end
        prev_req = coinReq;
        prev_fault = fault;
      end
    end
  end

  task automatic drain(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk({nm, "_drain"}, q.size(), 0);
    repeat (2) @(negedge clock);
  endtask

  task automatic pay(input int amt, input bit stall_first);
    @(negedge clock);
    moneyToGive = 5'd0;
    repeat (3) @(negedge clock);
    push_payout(amt, stall_first);
    moneyToGive = 5'(amt);
  endtask

  task automatic clear_fault_pulse();
    @(negedge clock);
    clearFault = 1;
    @(negedge clock);
    clearFault = 0;
  endtask

  initial begin
    int n;
    reset = 0;
    moneyToGive = 0;
    clearFault = 0;
    #12;
    chk("rst_coinReq", int'(coinReq), 0);
    chk("rst_coinSel", int'(coinSel), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_paidTotal", int'(paidTotal), 0);
    @(negedge clock);
    reset = 1;

    // 13 with ack two cycles after request
    ack_dly = 2; rel_dly = 0;
    pay(13, 0);
    @(negedge clock);
    chk("req_latency", int'(coinReq), 1);
    drain("pay13");

    // Exact payment: done one cycle after latch, no repeat while held
    pay(31, 0);
    @(negedge clock);
    chk("done31_latency", int'(done), 1);
    repeat (20) @(negedge clock);
    chk("hold31_queue", q.size(), 0);
    chk("hold31_no_req", int'(coinReq), 0);

    // Hopper never acknowledges
    never_ack = 1;
    pay(1, 1);
    n = 0;
    while (!coinReq && n < 20) begin @(negedge clock); n++; end
    n = 0;
    while (coinReq && n < 40) begin n++; @(negedge clock); end
    chk("req_cycles_to_fault", n, 15);
    chk("fault_set", int'(fault), 1);
    drain("stall1");
    never_ack = 0;
    clear_fault_pulse();
    chk("fault_cleared", int'(fault), 0);
    repeat (20) @(negedge clock);
    chk("no_repay_after_clear", int'(busy), 0);

    // Reset mid-payout of 7
    ack_dly = 2;
    pay(7, 0);
    n = 0;
    while (paidTotal != 5'd5 && n < 100) begin @(negedge clock); n++; end
    chk("first_coin_paid", int'(paidTotal), 5);
    #2 reset = 0;
    #1;
    chk("async_rst_req", int'(coinReq), 0);
    chk("async_rst_paid", int'(paidTotal), 0);
    q.delete();
    push_payout(7, 0);
    @(negedge clock);
    reset = 1;
    drain("rerun7");

    // Ack on the last permitted cycle is accepted; one later faults
    ack_dly = 15;
    pay(7, 0);
    drain("ack_at_limit");
    chk("no_fault_at_limit", int'(fault), 0);
    ack_dly = 16;
    pay(7, 1);
    drain("ack_past_limit");
    clear_fault_pulse();

    // Input change mid-payout is ignored
    ack_dly = 2; rel_dly = 1;
    pay(13, 0);
    repeat (4) @(negedge clock);
    moneyToGive = 5'd4;
    drain("change13to4");

    // Large amount exercises the coin counters when present
    pay(28, 0);
    drain("pay28");

    // Randomized payouts
    for (int i = 0; i < 25; i++) begin
      int amt;
      amt = $urandom_range(1, 31);
      ack_dly = $urandom_range(1, 5);
      rel_dly = $urandom_range(0, 3);
      pay(amt, 0);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 6)) @(negedge clock);
        moneyToGive = 5'($urandom_range(1, 31));
      end
      drain("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
